gate_test_sequencer: RTL and testbench
======================================

Name: gate_test_sequencer

Overview:
Synthesizable self-checking stimulus/response engine for a 2-input combinational gate under test. On a start request it drives the four input vectors 00, 01, 10, 11 in order. For each vector it waits a programmable settle time, samples the gate output and compares it with a parameterized truth table. It counts mismatches, records the first failing vector, and reports done/pass. It sits beside a gate instance on the lab board or in a wrapper, replacing a simulation-only bench.

Parameters:
SETTLE_CYCLES, 1, clock periods dut_out is allowed to settle after inputs change; legal range 1..15.
TRUTH_TABLE, 4'b0111, expected dut_out indexed by {dut_in1,dut_in2}; the default is NAND.

Ports:
clock  input  1  system clock, rising-edge active.
reset_n  input  1  asynchronous active-low reset.
start  input  1  run request, sampled only in IDLE.
dut_out  input  1  output of the gate under test.
dut_in1  output  1  stimulus MSB of the vector index (registered).
dut_in2  output  1  stimulus LSB of the vector index (registered).
busy  output  1  high while a run is in progress.
done  output  1  sticky; high from end of run until next accepted start.
pass  output  1  valid while done=1; 1 when err_count==0.
err_count  output  3  mismatches in the current/last run, 0..4.
first_err_valid  output  1  at least one mismatch recorded this run.
first_err_vec  output  2  {dut_in1,dut_in2} of the first mismatch.

Behaviour:
- One clock domain; single synchronous FSM, states IDLE, SETTLE, CHECK.
- Reset (reset_n=0, asynchronous):
  - state=IDLE.
  - Every output is 0: dut_in1/dut_in2, busy, done, pass, err_count, first_err_valid, first_err_vec.
  - Reset mid-run aborts immediately; no run resumes after release.
- IDLE, start=1 at edge E0 (accepted start):
  - vec<=00, drive dut_in<=00.
  - settle counter<=SETTLE_CYCLES-1.
  - Clear err_count, first_err_valid, first_err_vec, done, pass.
  - busy<=1, state<=SETTLE.
- SETTLE:
  - Counter==0 -> state<=CHECK.
  - Otherwise decrement the counter.
  - Inputs are held constant.
- CHECK, at a single edge:
  - Compare dut_out against TRUTH_TABLE[vec].
  - On mismatch: err_count<=err_count+1. If first_err_valid==0: first_err_vec<=vec and first_err_valid<=1.
  - If vec!=11: vec<=vec+1, dut_in<=vec+1, reload counter, state<=SETTLE.
  - If vec==11: state<=IDLE, busy<=0, done<=1, pass<=(no mismatch including this one). dut_in holds 11.
- Timing with S=SETTLE_CYCLES:
  - Vector k is driven from edge E0+k(S+1).
  - Vector k is checked at edge E0+(k+1)(S+1).
  - done rises at edge E0+4(S+1); with the default S=1 that is E0+8.
  - dut_out is sampled S+1 periods after its inputs change.
- start while busy is ignored (no restart, no queueing).
- start held high continuously: a new run is accepted on the first edge after returning to IDLE, i.e. the edge after done rises. That edge clears done.
- err_count saturation is not needed; the maximum is 4, which fits in 3 bits. There is no wrap.
- Mismatch definition:
  - Any sampled value other than the expected bit is an error.
  - In simulation the checker uses case inequality, so X or Z on dut_out counts as an error.
- TRUTH_TABLE bit index: 0=vec 00, 1=vec 01, 2=vec 10, 3=vec 11.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles, toggling start -> all outputs 0, busy stays 0. Release reset_n with start=0 -> busy stays 0.
2. Correct NAND model, defaults, one-cycle start pulse at E0:
   - dut_in sequence 00,01,10,11, each held 2 cycles.
   - busy high E0..E8; done=1 and pass=1 at E8.
   - err_count=0, first_err_valid=0.
3. Stuck-at-1 dut_out with defaults:
   - err_count=1, first_err_valid=1, first_err_vec=11, pass=0, done at E0+8.
4. AND model connected (TRUTH_TABLE still NAND):
   - All four vectors mismatch -> err_count=4, first_err_vec=00, pass=0.
   - Then start again with the NAND model -> done clears at the accepted start edge, and the run ends with pass=1, err_count=0.
5. start held high throughout with SETTLE_CYCLES=3 and the NAND model:
   - First done at E0+16.
   - Mid-run start causes no restart.
   - The next run is accepted at E0+17, clearing done.
6. Async reset mid-run: assert reset_n=0 between edges E4 and E5 (default S) -> busy, dut_in, err_count drop to 0 without waiting for a clock edge. After release the FSM stays in IDLE until start.

Source files
------------

// File: rtl/gate_test_sequencer.sv
// Stimulus/response checker for a 2-input combinational gate: walks vectors 00..11,
// waits SETTLE_CYCLES after each change, compares dut_out against TRUTH_TABLE.
module gate_test_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [3:0]  TRUTH_TABLE   = 4'b0111
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       first_err_valid,
    output logic [1:0] first_err_vec
);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck} state_e;

    localparam logic [3:0] Reload = 4'(SETTLE_CYCLES - 1);

    state_e     state;
    logic [1:0] vec;
    logic [3:0] cnt;
    logic       mismatch;

    // Case inequality so an X/Z gate output is flagged as a failure in simulation.
    always_comb mismatch = (dut_out !== TRUTH_TABLE[vec]);

    // vec is a register, so the stimulus outputs stay registered.
    assign dut_in1 = vec[1];
    assign dut_in2 = vec[0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= StIdle;
            vec             <= 2'b00;
            cnt             <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 3'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 2'b00;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        vec             <= 2'b00;
                        cnt             <= Reload;
                        err_count       <= 3'd0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= 2'b00;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                        state           <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt == 4'd0) begin
                        state <= StCheck;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        err_count <= err_count + 3'd1;
                        if (!first_err_valid) begin
                            first_err_vec   <= vec;
                            first_err_valid <= 1'b1;
                        end
                    end
                    if (vec != 2'b11) begin
                        vec   <= vec + 2'd1;
                        cnt   <= Reload;
                        state <= StSettle;
                    end else begin
                        // Last vector: stimulus stays at 11 until the next run.
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 3'd0) && !mismatch;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: two instances (settle 1 and 3) each driving a
// table-programmable gate model; table vectors, corner sequences and random runs.
module tb_gate_test_sequencer;

    localparam logic [3:0] Nand = 4'b0111;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       start_v   [2];
    logic [3:0] gate_v    [2];
    logic       dut_out_v [2];
    logic       in1_v     [2];
    logic       in2_v     [2];
    logic       busy_v    [2];
    logic       done_v    [2];
    logic       pass_v    [2];
    logic       fev_v     [2];
    logic [2:0] ec_v      [2];
    logic [1:0] fvec_v    [2];

    int errors = 0;
    int checks = 0;

    assign dut_out_v[0] = gate_v[0][{in1_v[0], in2_v[0]}];
    assign dut_out_v[1] = gate_v[1][{in1_v[1], in2_v[1]}];

    gate_test_sequencer u_s1 (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start_v[0]),
        .dut_out        (dut_out_v[0]),
        .dut_in1        (in1_v[0]),
        .dut_in2        (in2_v[0]),
        .busy           (busy_v[0]),
        .done           (done_v[0]),
        .pass           (pass_v[0]),
        .err_count      (ec_v[0]),
        .first_err_valid(fev_v[0]),
        .first_err_vec  (fvec_v[0])
    );

    gate_test_sequencer #(.SETTLE_CYCLES(3)) u_s3 (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start_v[1]),
        .dut_out        (dut_out_v[1]),
        .dut_in1        (in1_v[1]),
        .dut_in2        (in2_v[1]),
        .busy           (busy_v[1]),
        .done           (done_v[1]),
        .pass           (pass_v[1]),
        .err_count      (ec_v[1]),
        .first_err_valid(fev_v[1]),
        .first_err_vec  (fvec_v[1])
    );

    typedef struct {
        logic [3:0] gate;
        int         errs;
        bit         fv;
        int         fvec;
        bit         pass;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Reference: count truth-table disagreements and locate the lowest failing vector.
    task automatic model(input logic [3:0] g, output int errs, output bit fv, output int fvec);
        errs = 0;
        fv   = 0;
        fvec = 0;
        for (int v = 0; v < 4; v++) begin
            if (g[v] != Nand[v]) begin
                errs++;
                if (!fv) begin
                    fv   = 1;
                    fvec = v;
                end
            end
        end
    endtask

    task automatic chk_idle_zero(input int i, input string tag);
        chk({tag, "_dut_in"}, {30'd0, in1_v[i], in2_v[i]}, 0);
        chk({tag, "_busy"}, busy_v[i], 0);
        chk({tag, "_done"}, done_v[i], 0);
        chk({tag, "_pass"}, pass_v[i], 0);
        chk({tag, "_err_count"}, ec_v[i], 0);
        chk({tag, "_first_valid"}, fev_v[i], 0);
        chk({tag, "_first_vec"}, fvec_v[i], 0);
    endtask

    // One full run from a start pulse; rnd toggles start randomly while it must be ignored.
    task automatic run(input int i, input logic [3:0] g, input bit rnd, input int e_errs,
                       input bit e_fv, input int e_fvec, input bit e_pass);
        int s, len, ev;
        s = settle_of(i);
        len = 4 * (s + 1);
        gate_v[i] = g;
        start_v[i] = 1'b1;
        @(posedge clock);
        #1;
        for (int k = 0; k <= len; k++) begin
            ev = k / (s + 1);
            if (ev > 3) ev = 3;
            chk("run_dut_in", {30'd0, in1_v[i], in2_v[i]}, ev);
            chk("run_busy", busy_v[i], k < len);
            chk("run_done", done_v[i], k == len);
            if (k < len) begin
                start_v[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                @(posedge clock);
                #1;
            end else begin
                start_v[i] = 1'b0;
            end
        end
        chk("run_err_count", ec_v[i], e_errs);
        chk("run_first_valid", fev_v[i], e_fv);
        chk("run_first_vec", fvec_v[i], e_fvec);
        chk("run_pass", pass_v[i], e_pass);
    endtask

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev, j, errs, fvec, i;
        bit fv;
        logic [3:0] g;

        tbl[0] = '{4'b0111, 0, 0, 0, 1};  // correct NAND
        tbl[1] = '{4'b1111, 1, 1, 3, 0};  // stuck-at-1
        tbl[2] = '{4'b1000, 4, 1, 0, 0};  // AND: every vector wrong
        tbl[3] = '{4'b0111, 0, 0, 0, 1};  // NAND again, clears previous result
        tbl[4] = '{4'b0000, 3, 1, 0, 0};  // stuck-at-0
        tbl[5] = '{4'b0110, 1, 1, 0, 0};  // XOR
        tbl[6] = '{4'b0011, 1, 1, 2, 0};  // follows in1 inverted

        // Reset held with start toggling.
        reset_n = 1'b0;
        for (int n = 0; n < 2; n++) begin
            start_v[n] = 1'b0;
            gate_v[n]  = Nand;
        end
        for (int c = 0; c < 3; c++) begin
            start_v[0] = ~start_v[0];
            start_v[1] = ~start_v[1];
            @(posedge clock);
            #1;
            chk_idle_zero(0, "rst_a");
            chk_idle_zero(1, "rst_b");
        end
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("post_rst_busy_a", busy_v[0], 0);
        chk("post_rst_busy_b", busy_v[1], 0);

        for (int t = 0; t < 7; t++)
            run(0, tbl[t].gate, 1'b0, tbl[t].errs, tbl[t].fv, tbl[t].fvec, tbl[t].pass);

        // start held high with settle 3: no restart mid-run, re-accept right after done.
        gate_v[1] = Nand;
        start_v[1] = 1'b1;
        @(posedge clock);
        #1;
        for (int k = 0; k <= 33; k++) begin
            j = (k < 17) ? k : k - 17;
            ev = j / 4;
            if (ev > 3) ev = 3;
            chk("hold_dut_in", {30'd0, in1_v[1], in2_v[1]}, ev);
            chk("hold_busy", busy_v[1], j < 16);
            chk("hold_done", done_v[1], j == 16);
            if (k == 17) begin
                chk("hold_reaccept_err", ec_v[1], 0);
                start_v[1] = 1'b0;
            end
            if (k < 33) begin
                @(posedge clock);
                #1;
            end
        end
        chk("hold_pass", pass_v[1], 1);
        chk("hold_err_count", ec_v[1], 0);

        // Asynchronous reset between E4 and E5 with an AND gate.
        gate_v[0] = 4'b1000;
        start_v[0] = 1'b1;
        @(posedge clock);
        #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("pre_abort_err_count", ec_v[0], 2);
        chk("pre_abort_dut_in", {30'd0, in1_v[0], in2_v[0]}, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_zero(0, "abort");
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            chk("abort_stay_idle_busy", busy_v[0], 0);
            chk("abort_stay_idle_done", done_v[0], 0);
        end

        // Randomised runs against the reference model.
        for (int r = 0; r < 24; r++) begin
            i = int'($urandom_range(0, 1));
            g = 4'($urandom);
            model(g, errs, fv, fvec);
            run(i, g, 1'b1, errs, fv, fvec, errs == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
